// File: rtl/ram_sdp_be_pipe.sv
// Simple-dual-port RAM with byte enables, 1/2-cycle read pipeline, collision
// forwarding, out-of-range protection and a post-reset clear sequencer.
module ram_sdp_be_pipe #(
  parameter int unsigned           WORD_WIDTH     = 32,
  parameter int unsigned           BYTE_WIDTH     = 8,
  parameter int unsigned           ADDR_WIDTH     = 8,
  parameter int unsigned           DEPTH          = 256,
  parameter int unsigned           READ_LATENCY   = 1,
  parameter int unsigned           READ_NEW_DATA  = 0,
  parameter int unsigned           CLEAR_ON_RESET = 1,
  parameter logic [WORD_WIDTH-1:0] INIT_VALUE     = '0
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic                                wren,
  input  logic [(WORD_WIDTH/BYTE_WIDTH)-1:0]  byteen,
  input  logic [ADDR_WIDTH-1:0]               write_addr,
  input  logic [WORD_WIDTH-1:0]               write_data,
  input  logic                                rden,
  input  logic [ADDR_WIDTH-1:0]               read_addr,
  output logic [WORD_WIDTH-1:0]               read_data,
  output logic                                read_valid,
  output logic                                init_busy,
  output logic                                init_done
);

  localparam int unsigned           NUM_BYTES = WORD_WIDTH / BYTE_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR  = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic                    init_done_q;
  logic                    clr_we;

  logic [WORD_WIDTH-1:0]   mem [DEPTH];

  logic                    ready;
  logic                    wr_en;
  logic                    rd_en;
  logic                    rd_in_range;
  logic                    collide;
  logic [WORD_WIDTH-1:0]   rd_old;
  logic [WORD_WIDTH-1:0]   rd_word;

  logic                    s1_valid_q;
  logic [WORD_WIDTH-1:0]   s1_data_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    clr_we  = 1'b0;
    if (state_q == ST_CLEAR) begin
      clr_we = 1'b1;
      ptr_d  = ptr_q + 1'b1;
      if (ptr_q == LAST_PTR) begin
        state_d = ST_READY;
      end
    end
  end

  // init_done is registered from the next state so it stays low during reset
  // even when no clear is configured.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      ptr_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      init_done_q <= (state_d == ST_READY);
    end
  end

  assign init_busy = (state_q == ST_CLEAR);
  assign init_done = init_done_q;

  assign ready       = (state_q == ST_READY);
  assign wr_en       = ready && wren && ({1'b0, write_addr} < DEPTH_W);
  assign rd_en       = ready && rden;
  assign rd_in_range = ({1'b0, read_addr} < DEPTH_W);
  assign collide     = (READ_NEW_DATA != 0) && wr_en && (write_addr == read_addr);

  always_ff @(posedge clock) begin
    if (reset_n) begin
      if (clr_we) begin
        mem[ptr_q] <= INIT_VALUE;
      end else if (wr_en) begin
        for (int unsigned i = 0; i < NUM_BYTES; i++) begin
          if (byteen[i]) begin
            mem[write_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= write_data[i*BYTE_WIDTH +: BYTE_WIDTH];
          end
        end
      end
    end
  end

  always_comb begin
    rd_old  = rd_in_range ? mem[read_addr] : '0;
    rd_word = rd_old;
    for (int unsigned i = 0; i < NUM_BYTES; i++) begin
      if (collide && byteen[i]) begin
        rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = write_data[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= rd_en;
      if (rd_en) begin
        s1_data_q <= rd_word;
      end
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  s2_valid_q;
      logic [WORD_WIDTH-1:0] s2_data_q;

      always_ff @(posedge clock) begin
        if (!reset_n) begin
          s2_valid_q <= 1'b0;
          s2_data_q  <= '0;
        end else begin
          s2_valid_q <= s1_valid_q;
          if (s1_valid_q) begin
            s2_data_q <= s1_data_q;
          end
        end
      end

      assign read_valid = s2_valid_q;
      assign read_data  = s2_data_q;
    end else begin : g_lat1
      assign read_valid = s1_valid_q;
      assign read_data  = s1_data_q;
    end
  endgenerate

endmodule

// File: tb/tb_ram_sdp_be_pipe.sv
// Bench for ram_sdp_be_pipe: two configurations share one stimulus stream,
// each with its own memory model and expected-read queue.
module tb_ram_sdp_be_pipe;

  logic        clock;
  logic        reset_n;
  logic        wren;
  logic [3:0]  byteen;
  logic [7:0]  write_addr;
  logic [31:0] write_data;
  logic        rden;
  logic [7:0]  read_addr;

  logic [31:0] rdA, rdB;
  logic        rvA, rvB, busyA, busyB, doneA, doneB;

  // A: 256 words, latency 1, old data on collision, clear to A5A5A5A5
  ram_sdp_be_pipe #(
    .WORD_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(256),
    .READ_LATENCY(1), .READ_NEW_DATA(0), .CLEAR_ON_RESET(1),
    .INIT_VALUE(32'hA5A5A5A5)
  ) uA (
    .clock(clock), .reset_n(reset_n), .wren(wren), .byteen(byteen),
    .write_addr(write_addr), .write_data(write_data), .rden(rden),
    .read_addr(read_addr), .read_data(rdA), .read_valid(rvA),
    .init_busy(busyA), .init_done(doneA)
  );

  // B: 200 words, latency 2, new data on collision, clear to zero
  ram_sdp_be_pipe #(
    .WORD_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(200),
    .READ_LATENCY(2), .READ_NEW_DATA(1), .CLEAR_ON_RESET(1),
    .INIT_VALUE(32'h00000000)
  ) uB (
    .clock(clock), .reset_n(reset_n), .wren(wren), .byteen(byteen),
    .write_addr(write_addr), .write_data(write_data), .rden(rden),
    .read_addr(read_addr), .read_data(rdB), .read_valid(rvB),
    .init_busy(busyB), .init_done(doneB)
  );

  typedef struct {
    int unsigned due;
    logic [31:0] data;
  } exp_t;

  exp_t        qA[$];
  exp_t        qB[$];
  logic [31:0] mA [256];
  logic [31:0] mB [256];
  logic [31:0] lastA, lastB;
  int unsigned cyc;
  int unsigned n_assert;
  int unsigned n_fail;
  bit          live;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[i*8 +: 8] = wd[i*8 +: 8];
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: a due entry must coincide with a valid pulse carrying its data.
  always @(negedge clock) begin
    bit          expA, expB;
    logic [31:0] edA, edB;
    expA = (qA.size() != 0) && (qA[0].due == cyc);
    expB = (qB.size() != 0) && (qB[0].due == cyc);
    edA  = (qA.size() != 0) ? qA[0].data : 32'h0;
    edB  = (qB.size() != 0) ? qB[0].data : 32'h0;
    if (expA || rvA === 1'b1) begin
      n_assert++;
      assert (rvA === 1'b1 && expA && rdA === edA) else begin
        n_fail++;
        $error("FAIL readA cyc=%0d observed valid=%b data=%h expected valid=%b data=%h",
               cyc, rvA, rdA, expA, edA);
      end
      if (expA) begin
        lastA = edA;
        void'(qA.pop_front());
      end
    end
    if (expB || rvB === 1'b1) begin
      n_assert++;
      assert (rvB === 1'b1 && expB && rdB === edB) else begin
        n_fail++;
        $error("FAIL readB cyc=%0d observed valid=%b data=%h expected valid=%b data=%h",
               cyc, rvB, rdB, expB, edB);
      end
      if (expB) begin
        lastB = edB;
        void'(qB.pop_front());
      end
    end
  end

  task automatic op(input logic wr, input logic [3:0] be, input logic [7:0] wa,
                    input logic [31:0] wd, input logic rd, input logic [7:0] ra);
    logic [31:0] eA, eB;
    wren       = wr;
    byteen     = be;
    write_addr = wa;
    write_data = wd;
    rden       = rd;
    read_addr  = ra;
    if (live) begin
      if (rd) begin
        eA = mA[ra];
        eB = (ra < 8'd200) ? mB[ra] : 32'h0;
        if (wr && wa == ra && ra < 8'd200) eB = merge(eB, wd, be);
        qA.push_back('{due: cyc + 1, data: eA});
        qB.push_back('{due: cyc + 2, data: eB});
      end
      if (wr) begin
        mA[wa] = merge(mA[wa], wd, be);
        if (wa < 8'd200) mB[wa] = merge(mB[wa], wd, be);
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) op(1'b0, 4'h0, 8'h0, 32'h0, 1'b0, 8'h0);
  endtask

  initial begin
    int unsigned tA, tB;
    logic [7:0]  wa, ra;
    n_assert = 0;
    n_fail   = 0;
    live     = 1'b0;
    lastA    = '0;
    lastB    = '0;
    reset_n  = 1'b0;
    idle(3);
    chk("reset_A", {rvA, rdA, busyA, doneA}, {1'b0, 32'h0, 1'b1, 1'b0});
    chk("reset_B", {rvB, rdB, busyB, doneB}, {1'b0, 32'h0, 1'b1, 1'b0});

    // First clear, interrupted at pointer 100 with traffic that must be ignored
    reset_n = 1'b1;
    for (int i = 0; i < 100; i++) op(1'b1, 4'hF, 8'd43, 32'hCAFEF00D, 1'b1, 8'd43);
    chk("midclear_busy", {busyA, busyB, doneA, doneB}, 4'b1100);
    reset_n = 1'b0;
    idle(1);
    chk("midreset_state", {busyA, busyB, doneA, doneB, rvA, rvB}, 6'b110000);

    // Restarted clear: writes/reads to addr 5 during CLEAR must have no effect
    reset_n    = 1'b1;
    wren       = 1'b1; byteen = 4'hF; write_addr = 8'd5; write_data = 32'h12345678;
    rden       = 1'b1; read_addr = 8'd5;
    tA = 0; tB = 0;
    for (int i = 1; i <= 400; i++) begin
      if (i == 190) begin
        wren = 1'b0;
        rden = 1'b0;
      end
      @(posedge clock);
      #1;
      if (doneA === 1'b1 && tA == 0) tA = i;
      if (doneB === 1'b1 && tB == 0) tB = i;
      if (tA != 0 && tB != 0) break;
    end
    chk("init_cycles_A", 64'(tA), 64'd256);
    chk("init_cycles_B", 64'(tB), 64'd200);
    chk("ready_flags", {busyA, busyB, doneA, doneB}, 4'b0011);

    for (int i = 0; i < 256; i++) begin
      mA[i] = 32'hA5A5A5A5;
      mB[i] = 32'h0;
    end
    live = 1'b1;

    // Cleared contents, including addr 5 that saw writes during CLEAR
    op(1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 8'd0);
    op(1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 8'd255);
    op(1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 8'd5);
    idle(3);

    // Byte-lane writes
    op(1'b1, 4'b1111, 8'd5, 32'h11223344, 1'b0, 8'd0);
    op(1'b1, 4'b0101, 8'd5, 32'hFFFFFFFF, 1'b0, 8'd0);
    op(1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 8'd5);
    op(1'b1, 4'b0000, 8'd5, 32'h0BADCAFE, 1'b0, 8'd0);
    op(1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 8'd5);
    idle(3);

    // Collision at addr 7 holding zero
    op(1'b1, 4'b1111, 8'd7, 32'h00000000, 1'b0, 8'd0);
    op(1'b1, 4'b0011, 8'd7, 32'hDEADBEEF, 1'b1, 8'd7);
    op(1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 8'd7);
    idle(3);

    // Back-to-back reads of addrs 0..3 and independent different-address traffic
    for (int i = 0; i < 4; i++) op(1'b1, 4'hF, 8'(i), 32'h1000_0000 + 32'(i) * 32'h0101_0101, 1'b0, 8'd0);
    for (int i = 0; i < 4; i++) op(1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 8'(i));
    op(1'b1, 4'hF, 8'd9, 32'h99999999, 1'b1, 8'd2);
    idle(3);

    // Out-of-range for the 200-word instance
    op(1'b1, 4'hF, 8'd250, 32'h55AA55AA, 1'b0, 8'd0);
    op(1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 8'd250);
    op(1'b1, 4'hF, 8'd199, 32'h77777777, 1'b1, 8'd199);
    op(1'b1, 4'hC, 8'd250, 32'h12121212, 1'b1, 8'd250);
    op(1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 8'd199);
    idle(3);

    // Mixed random traffic with frequent collisions and boundary addresses
    for (int i = 0; i < 60; i++) begin
      wa = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(190, 255)) : 8'($urandom_range(0, 12));
      ra = ($urandom_range(0, 2) == 0) ? wa : 8'($urandom_range(0, 12));
      op(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), wa, $urandom,
         1'($urandom_range(0, 1)), ra);
    end
    op(1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 8'd3);
    idle(5);

    chk("queue_empty", {32'(qA.size()), 32'(qB.size())}, 64'h0);
    chk("hold_A", {rvA, rdA}, {1'b0, lastA});
    chk("hold_B", {rvB, rdB}, {1'b0, lastB});

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
